// File: rtl/seg7_scan_driver.sv
// Three-digit multiplexed 7-segment driver: converts an 8-bit binary count to BCD
// with a one-bit-per-cycle double-dabble and scans ones/tens/hundreds continuously.
module seg7_scan_driver #(
    parameter int          REFRESH_DIV   = 1000,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic [2:0] dig_en
);

    localparam int              CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit              BLANK_EN = (BLANK_LEADING != 0);

    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("seg7_scan_driver: REFRESH_DIV must be >= 2");
    end

    typedef enum logic [1:0] {
        DIG_ONES  = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_HUNDS = 2'd2
    } digit_e;

    function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [6:0] decode_digit(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // ---------------------------------------------------------------- conversion
    logic        r_busy;
    logic [2:0]  r_iter;
    logic [7:0]  r_bin;
    logic [11:0] r_bcd;
    logic [3:0]  r_hund;
    logic [3:0]  r_tens;
    logic [3:0]  r_ones;

    logic [11:0] w_bcd_adj;
    logic [11:0] w_bcd_next;
    logic [7:0]  w_bin_next;

    // Adjust every nibble first, then shift the next binary MSB into the BCD scratch.
    assign w_bcd_adj  = {add3_if_ge5(r_bcd[11:8]), add3_if_ge5(r_bcd[7:4]), add3_if_ge5(r_bcd[3:0])};
    assign w_bcd_next = {w_bcd_adj[10:0], r_bin[7]};
    assign w_bin_next = {r_bin[6:0], 1'b0};

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_iter <= 3'd0;
            r_bin  <= 8'd0;
            r_bcd  <= 12'd0;
            r_hund <= 4'd0;
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (r_busy) begin
            r_bin  <= w_bin_next;
            r_bcd  <= w_bcd_next;
            r_iter <= r_iter + 3'd1;
            // Display digits change only once, from the fully converted result.
            if (r_iter == 3'd7) begin
                r_busy <= 1'b0;
                r_hund <= w_bcd_next[11:8];
                r_tens <= w_bcd_next[7:4];
                r_ones <= w_bcd_next[3:0];
            end
        end else if (load) begin
            r_busy <= 1'b1;
            r_iter <= 3'd0;
            r_bin  <= value;
            r_bcd  <= 12'd0;
        end
    end

    assign busy = r_busy;

    // ---------------------------------------------------------------- scanning
    logic [CNT_W-1:0] r_refresh_cnt;
    digit_e           r_digit;
    logic [6:0]       r_seg;
    logic [2:0]       r_dig_en;

    logic             w_wrap;
    digit_e           w_digit_next;
    logic             w_blank_hund;
    logic             w_blank_tens;
    logic [6:0]       w_seg_next;
    logic [2:0]       w_dig_en_next;

    assign w_wrap       = (r_refresh_cnt == CNT_LAST);
    assign w_blank_hund = BLANK_EN && (r_hund == 4'd0);
    assign w_blank_tens = BLANK_EN && (r_hund == 4'd0) && (r_tens == 4'd0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_digit_next = r_digit;
        if (w_wrap) begin
            case (r_digit)
                DIG_ONES: w_digit_next = DIG_TENS;
                DIG_TENS: w_digit_next = DIG_HUNDS;
                default:  w_digit_next = DIG_ONES;
            endcase
        end
    end

    // Segments and enable are computed for the upcoming digit so both registers flip together.
    always_comb begin
        w_seg_next    = decode_digit(r_ones);
        w_dig_en_next = 3'b001;
        case (w_digit_next)
            DIG_TENS: begin
                w_dig_en_next = 3'b010;
                w_seg_next    = w_blank_tens ? 7'h00 : decode_digit(r_tens);
            end
            DIG_HUNDS: begin
                w_dig_en_next = 3'b100;
                w_seg_next    = w_blank_hund ? 7'h00 : decode_digit(r_hund);
            end
            default: begin
                w_dig_en_next = 3'b001;
                w_seg_next    = decode_digit(r_ones);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_digit       <= DIG_ONES;
            r_seg         <= 7'h3F;
            r_dig_en      <= 3'b001;
        end else begin
            r_refresh_cnt <= w_wrap ? '0 : r_refresh_cnt + CNT_ONE;
            r_digit       <= w_digit_next;
            r_seg         <= w_seg_next;
            r_dig_en      <= w_dig_en_next;
        end
    end

    assign seg    = r_seg;
    assign dig_en = r_dig_en;

endmodule
